// File: rtl/pxs_pkg.sv
// Shared definitions for the Pxs pixel-stream stages: stream field layout,
// coordinate widths, the ball-updater state type and the speed helper.
package pxs_pkg;

    // 26-bit stream layout {B,G,R,XC[9:0],YC[9:0],HS,VS,Active}
    localparam int ACT     = 0;
    localparam int VS      = 1;
    localparam int HS      = 2;
    localparam int YC_LSB  = 3;
    localparam int XC_LSB  = 13;
    localparam int RGB_LSB = 23;
    localparam int STR_W   = 26;

    // Coordinate width and the one-bit-wider width used for signed diffs / sums
    localparam int CW  = 10;
    localparam int AW  = 11;
    localparam int SPW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UPD  = 2'd1,
        DONE = 2'd2
    } upd_state_t;

    // Saturating speed step; simultaneous inc and dec cancel out
    function automatic logic [SPW-1:0] next_speed(
        input logic [SPW-1:0] cur,
        input logic           inc,
        input logic           dec,
        input logic [SPW-1:0] max_spd
    );
        logic [SPW-1:0] res;
        res = cur;
        if (inc && !dec && (cur < max_spd)) begin
            res = cur + 4'd1;
        end else if (dec && !inc && (cur != 4'd0)) begin
            res = cur - 4'd1;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/pxs_bounce_step.sv
// One-axis position step with exact clamping at 0 and LIM.
// Landing exactly on an edge counts as a bounce and reverses direction.
module pxs_bounce_step
    import pxs_pkg::*;
(
    input  logic [CW-1:0]  p,
    input  logic           dir,
    input  logic [SPW-1:0] speed,
    input  logic [CW-1:0]  lim,
    output logic [CW-1:0]  p_next,
    output logic           dir_next,
    output logic           bounced
);

    logic [AW-1:0] sum_s;

    assign sum_s = {1'b0, p} + {7'b0, speed};

    // Advance or retreat by speed, clamping to the edge instead of overshooting
    always_comb begin
        p_next   = p;
        dir_next = dir;
        bounced  = 1'b0;
        if (dir == 1'b0) begin
            if (sum_s >= {1'b0, lim}) begin
                p_next   = lim;
                dir_next = 1'b1;
                bounced  = 1'b1;
            end else begin
                p_next   = sum_s[CW-1:0];
            end
        end else begin
            if ({1'b0, p} <= {7'b0, speed}) begin
                p_next   = {CW{1'b0}};
                dir_next = 1'b0;
                bounced  = 1'b1;
            end else begin
                p_next   = p - {6'b0, speed};
            end
        end
    end

endmodule

// File: rtl/pxs_multi_ball.sv
// Pixel-stream overlay drawing NUM_BALLS solid bouncing rectangles.
// Three-stage pipeline (hit test, priority encode, RGB mux) plus a per-frame
// sequential position updater. Optional feature macro: PXS_BALL_HIT_EN adds
// hit_o, a one-cycle pulse when any ball bounced during the frame sweep.
module pxs_multi_ball
    import pxs_pkg::*;
#(
    parameter int          NUM_BALLS  = 4,
    parameter int          BALL_W     = 32,
    parameter int          BALL_H     = 32,
    parameter int          COLS       = 640,
    parameter int          ROWS       = 480,
    parameter int          INIT_SPEED = 1,
    parameter int          MAX_SPEED  = 15,
    parameter int          X_SPACING  = 96,
    parameter int          Y_SPACING  = 64,
    parameter logic [23:0] BALL_RGB   = 24'o76543217
)(
    input  logic             px_clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             speed_inc_i,
    input  logic             speed_dec_i,
    input  logic [STR_W-1:0] RGBStr_i,
    output logic [STR_W-1:0] RGBStr_o
`ifdef PXS_BALL_HIT_EN
    ,
    output logic             hit_o
`endif
);

    localparam logic [CW-1:0]  LIM_X    = CW'(COLS - BALL_W);
    localparam logic [CW-1:0]  LIM_Y    = CW'(ROWS - BALL_H);
    localparam logic [CW-1:0]  TRIG_X   = CW'(COLS - 1);
    localparam logic [CW-1:0]  TRIG_Y   = CW'(ROWS - 1);
    localparam logic [2:0]     LAST_IDX = 3'(NUM_BALLS - 1);
    localparam logic [SPW-1:0] INIT_SPD = SPW'(INIT_SPEED);
    localparam logic [SPW-1:0] MAX_SPD  = SPW'(MAX_SPEED);

    if ((NUM_BALLS < 1) || (NUM_BALLS > 8)) begin : g_bad_num
        $error("pxs_multi_ball: NUM_BALLS must be 1..8");
    end
    if ((NUM_BALLS - 1) * X_SPACING > COLS - BALL_W) begin : g_bad_xsp
        $error("pxs_multi_ball: X_SPACING places a ball beyond COLS-BALL_W");
    end
    if ((NUM_BALLS - 1) * Y_SPACING > ROWS - BALL_H) begin : g_bad_ysp
        $error("pxs_multi_ball: Y_SPACING places a ball beyond ROWS-BALL_H");
    end

    // Ball state
    logic [CW-1:0]        x_r [NUM_BALLS];
    logic [CW-1:0]        y_r [NUM_BALLS];
    logic [NUM_BALLS-1:0] dx_r;
    logic [NUM_BALLS-1:0] dy_r;
    logic [SPW-1:0]       speed_r;
    logic                 pend_inc_r;
    logic                 pend_dec_r;
    upd_state_t           state_r;
    logic [2:0]           idx_r;

    // Pipeline
    logic [NUM_BALLS-1:0] inside_s;
    logic [NUM_BALLS-1:0] inside_r;
    logic [STR_W-1:0]     str0_r;
    logic [STR_W-1:0]     str1_r;
    logic                 hit_s;
    logic [2:0]           col_s;
    logic                 hit1_r;
    logic [2:0]           col1_r;

    // Updater datapath
    logic [CW-1:0] xc_in_s;
    logic [CW-1:0] yc_in_s;
    logic          trig_s;
    logic [CW-1:0] cur_x_s;
    logic [CW-1:0] cur_y_s;
    logic          cur_dx_s;
    logic          cur_dy_s;
    logic [CW-1:0] nx_s;
    logic [CW-1:0] ny_s;
    logic          ndx_s;
    logic          ndy_s;
    logic          bx_bounce_s;
    logic          by_bounce_s;

    assign xc_in_s = RGBStr_i[XC_LSB +: CW];
    assign yc_in_s = RGBStr_i[YC_LSB +: CW];
    assign trig_s  = en_i && (xc_in_s == TRIG_X) && (yc_in_s == TRIG_Y);

    // S0 hit test: 11-bit signed offsets, inside when 0 <= offset < size
    for (genvar gi = 0; gi < NUM_BALLS; gi++) begin : g_ball
        logic [AW-1:0] bx_s;
        logic [AW-1:0] by_s;
        assign bx_s = {1'b0, xc_in_s} - {1'b0, x_r[gi]};
        assign by_s = {1'b0, yc_in_s} - {1'b0, y_r[gi]};
        assign inside_s[gi] = (bx_s[AW-1] == 1'b0) && (bx_s < AW'(BALL_W)) &&
                              (by_s[AW-1] == 1'b0) && (by_s < AW'(BALL_H));
    end

    // S1 priority encode: iterate high to low so the lowest index wins
    always_comb begin
        hit_s = 1'b0;
        col_s = 3'b000;
        for (int i = NUM_BALLS - 1; i >= 0; i--) begin
            hit_s = hit_s | inside_r[i];
            col_s = inside_r[i] ? BALL_RGB[3*i +: 3] : col_s;
        end
    end

    // Three-stage overlay pipeline; non-colour fields pass through untouched
    always_ff @(posedge px_clk) begin
        if (rst) begin
            inside_r <= {NUM_BALLS{1'b0}};
            str0_r   <= {STR_W{1'b0}};
            str1_r   <= {STR_W{1'b0}};
            hit1_r   <= 1'b0;
            col1_r   <= 3'b000;
            RGBStr_o <= {STR_W{1'b0}};
        end else begin
            inside_r <= inside_s;
            str0_r   <= RGBStr_i;
            str1_r   <= str0_r;
            hit1_r   <= hit_s;
            col1_r   <= col_s;
            RGBStr_o <= {(hit1_r && str1_r[ACT] && en_i) ? col1_r : str1_r[RGB_LSB +: 3],
                         str1_r[RGB_LSB-1:0]};
        end
    end

    // Select the ball currently addressed by the updater
    always_comb begin
        cur_x_s  = {CW{1'b0}};
        cur_y_s  = {CW{1'b0}};
        cur_dx_s = 1'b0;
        cur_dy_s = 1'b0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            cur_x_s  = cur_x_s  | (x_r[i] & {CW{idx_r == 3'(i)}});
            cur_y_s  = cur_y_s  | (y_r[i] & {CW{idx_r == 3'(i)}});
            cur_dx_s = cur_dx_s | (dx_r[i] & (idx_r == 3'(i)));
            cur_dy_s = cur_dy_s | (dy_r[i] & (idx_r == 3'(i)));
        end
    end

    pxs_bounce_step u_step_x (
        .p        (cur_x_s),
        .dir      (cur_dx_s),
        .speed    (speed_r),
        .lim      (LIM_X),
        .p_next   (nx_s),
        .dir_next (ndx_s),
        .bounced  (bx_bounce_s)
    );

    pxs_bounce_step u_step_y (
        .p        (cur_y_s),
        .dir      (cur_dy_s),
        .speed    (speed_r),
        .lim      (LIM_Y),
        .p_next   (ny_s),
        .dir_next (ndy_s),
        .bounced  (by_bounce_s)
    );

`ifdef PXS_BALL_HIT_EN
    logic bounce_acc_r;
`else
    logic unused_bounce_s;
    assign unused_bounce_s = bx_bounce_s ^ by_bounce_s;
`endif

    // Frame updater: latch speed on entry, then sweep one ball per cycle
    always_ff @(posedge px_clk) begin
        if (rst) begin
            state_r    <= IDLE;
            idx_r      <= 3'd0;
            speed_r    <= INIT_SPD;
            pend_inc_r <= 1'b0;
            pend_dec_r <= 1'b0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                x_r[i]  <= CW'(i * X_SPACING);
                y_r[i]  <= CW'(i * Y_SPACING);
                dx_r[i] <= 1'(i % 2);
                dy_r[i] <= 1'((i / 2) % 2);
            end
`ifdef PXS_BALL_HIT_EN
            bounce_acc_r <= 1'b0;
            hit_o        <= 1'b0;
`endif
        end else begin
            pend_inc_r <= pend_inc_r | speed_inc_i;
            pend_dec_r <= pend_dec_r | speed_dec_i;
            case (state_r)
                IDLE: begin
                    if (trig_s) begin
                        state_r    <= UPD;
                        idx_r      <= 3'd0;
                        speed_r    <= next_speed(speed_r, pend_inc_r | speed_inc_i,
                                                 pend_dec_r | speed_dec_i, MAX_SPD);
                        pend_inc_r <= 1'b0;
                        pend_dec_r <= 1'b0;
`ifdef PXS_BALL_HIT_EN
                        bounce_acc_r <= 1'b0;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                UPD: begin
                    for (int i = 0; i < NUM_BALLS; i++) begin
                        if (idx_r == 3'(i)) begin
                            x_r[i]  <= nx_s;
                            y_r[i]  <= ny_s;
                            dx_r[i] <= ndx_s;
                            dy_r[i] <= ndy_s;
                        end
                    end
`ifdef PXS_BALL_HIT_EN
                    bounce_acc_r <= bounce_acc_r | bx_bounce_s | by_bounce_s;
`endif
                    if (idx_r == LAST_IDX) begin
                        state_r <= DONE;
`ifdef PXS_BALL_HIT_EN
                        hit_o   <= bounce_acc_r | bx_bounce_s | by_bounce_s;
`endif
                    end else begin
                        idx_r <= idx_r + 3'd1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
`ifdef PXS_BALL_HIT_EN
                    hit_o   <= 1'b0;
`endif
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pxs_multi_ball.sv
// Directed self-checking bench for pxs_multi_ball (2 balls, 96/16 spacing).
module tb_pxs_multi_ball;
    import pxs_pkg::*;

    localparam logic [23:0] RGBP = 24'o00000035; // ball0 = 3'b101, ball1 = 3'b011
    localparam logic [2:0]  C0   = 3'b101;
    localparam logic [2:0]  C1   = 3'b011;
    localparam logic [2:0]  BG   = 3'b110;

    logic             px_clk = 1'b0;
    logic             rst = 1'b1;
    logic             en_i = 1'b1;
    logic             speed_inc_i = 1'b0;
    logic             speed_dec_i = 1'b0;
    logic [STR_W-1:0] RGBStr_i;
    logic [STR_W-1:0] RGBStr_o;
`ifdef PXS_BALL_HIT_EN
    logic             hit_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 px_clk = ~px_clk;

    pxs_multi_ball #(
        .NUM_BALLS (2),
        .X_SPACING (96),
        .Y_SPACING (16),
        .BALL_RGB  (RGBP)
    ) dut (
        .px_clk      (px_clk),
        .rst         (rst),
        .en_i        (en_i),
        .speed_inc_i (speed_inc_i),
        .speed_dec_i (speed_dec_i),
        .RGBStr_i    (RGBStr_i),
        .RGBStr_o    (RGBStr_o)
`ifdef PXS_BALL_HIT_EN
        ,
        .hit_o       (hit_o)
`endif
    );

    function automatic logic [STR_W-1:0] pix(input logic [2:0] rgb, input logic [9:0] xc,
                                             input logic [9:0] yc, input logic act);
        logic [STR_W-1:0] s;
        s = {STR_W{1'b0}};
        s[RGB_LSB +: 3] = rgb;
        s[XC_LSB +: CW] = xc;
        s[YC_LSB +: CW] = yc;
        s[HS]  = 1'b0;
        s[VS]  = 1'b0;
        s[ACT] = act;
        return s;
    endfunction

    task automatic tick;
        @(posedge px_clk);
        #1;
    endtask

    task automatic idle_px;
        RGBStr_i = pix(3'b000, 10'd700, 10'd500, 1'b0);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_px();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Optional speed pulse, then one frame trigger, then wait out the sweep
    task automatic frame(input logic inc, input logic dec, output int hits);
        hits = 0;
        if (inc || dec) begin
            speed_inc_i = inc;
            speed_dec_i = dec;
            tick();
            speed_inc_i = 1'b0;
            speed_dec_i = 1'b0;
            tick();
            tick();
        end
        RGBStr_i = pix(3'b000, 10'd639, 10'd479, 1'b0);
        tick();
        idle_px();
        for (int k = 0; k < 6; k++) begin
`ifdef PXS_BALL_HIT_EN
            if (hit_o === 1'b1) hits++;
`endif
            tick();
        end
    endtask

    task automatic frames(input int n, input logic inc, input logic dec);
        int h;
        for (int k = 0; k < n; k++) frame(inc, dec, h);
    endtask

    // Drive one pixel and return the output three clocks later
    task automatic probe(input logic [2:0] rgb, input logic [9:0] xc, input logic [9:0] yc,
                         input logic act, output logic [STR_W-1:0] o);
        RGBStr_i = pix(rgb, xc, yc, act);
        tick();
        idle_px();
        tick();
        tick();
        o = RGBStr_o;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle_px();
        tick();
        tick();
        total++; if (RGBStr_o !== 26'd0) begin bad++; $display("FAIL rst_out got=%h exp=0", RGBStr_o); end
        total++; if (dut.speed_r !== 4'd1) begin bad++; $display("FAIL rst_speed got=%0d exp=1", dut.speed_r); end
        total++; if (dut.state_r !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=0", dut.state_r); end
        total++; if (dut.x_r[1] !== 10'd96) begin bad++; $display("FAIL rst_x1 got=%0d exp=96", dut.x_r[1]); end
        total++; if (dut.y_r[1] !== 10'd16) begin bad++; $display("FAIL rst_y1 got=%0d exp=16", dut.y_r[1]); end
        total++; if (dut.dx_r !== 2'b10) begin bad++; $display("FAIL rst_dx got=%b exp=10", dut.dx_r); end
        total++; if (dut.dy_r !== 2'b00) begin bad++; $display("FAIL rst_dy got=%b exp=00", dut.dy_r); end
`ifdef PXS_BALL_HIT_EN
        total++; if (hit_o !== 1'b0) begin bad++; $display("FAIL rst_hit got=%b exp=0", hit_o); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_overlay;
        logic [STR_W-1:0] o;
        logic [STR_W-1:0] idle_o;
        idle_o = pix(3'b000, 10'd700, 10'd500, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        RGBStr_i = pix(BG, 10'd0, 10'd0, 1'b1);
        tick();
        idle_px();
        total++; if (RGBStr_o !== idle_o) begin bad++; $display("FAIL lat_c1 got=%h exp=%h", RGBStr_o, idle_o); end
        tick();
        total++; if (RGBStr_o !== idle_o) begin bad++; $display("FAIL lat_c2 got=%h exp=%h", RGBStr_o, idle_o); end
        tick();
        total++; if (RGBStr_o !== pix(C0, 10'd0, 10'd0, 1'b1)) begin bad++; $display("FAIL lat_c3 got=%h exp=%h", RGBStr_o, pix(C0, 10'd0, 10'd0, 1'b1)); end
        probe(BG, 10'd96, 10'd16, 1'b1, o);
        total++; if (o !== pix(C1, 10'd96, 10'd16, 1'b1)) begin bad++; $display("FAIL ball1_corner got=%h exp=%h", o, pix(C1, 10'd96, 10'd16, 1'b1)); end
        probe(BG, 10'd31, 10'd31, 1'b1, o);
        total++; if (o !== pix(C0, 10'd31, 10'd31, 1'b1)) begin bad++; $display("FAIL ball0_last got=%h exp=%h", o, pix(C0, 10'd31, 10'd31, 1'b1)); end
        probe(BG, 10'd32, 10'd0, 1'b1, o);
        total++; if (o !== pix(BG, 10'd32, 10'd0, 1'b1)) begin bad++; $display("FAIL ball0_right got=%h exp=%h", o, pix(BG, 10'd32, 10'd0, 1'b1)); end
        probe(BG, 10'd127, 10'd47, 1'b1, o);
        total++; if (o !== pix(C1, 10'd127, 10'd47, 1'b1)) begin bad++; $display("FAIL ball1_last got=%h exp=%h", o, pix(C1, 10'd127, 10'd47, 1'b1)); end
        probe(BG, 10'd128, 10'd16, 1'b1, o);
        total++; if (o !== pix(BG, 10'd128, 10'd16, 1'b1)) begin bad++; $display("FAIL ball1_right got=%h exp=%h", o, pix(BG, 10'd128, 10'd16, 1'b1)); end
        probe(BG, 10'd96, 10'd15, 1'b1, o);
        total++; if (o !== pix(BG, 10'd96, 10'd15, 1'b1)) begin bad++; $display("FAIL ball1_above got=%h exp=%h", o, pix(BG, 10'd96, 10'd15, 1'b1)); end
    endtask

    task automatic test_clamp_right;
        int h;
        do_reset();
        frame(1'b1, 1'b0, h);
        frame(1'b0, 1'b0, h);
        frames(13, 1'b1, 1'b0);
        frames(26, 1'b0, 1'b0);
        frames(10, 1'b0, 1'b1);
        total++; if (dut.x_r[0] !== 10'd606) begin bad++; $display("FAIL cr_x606 got=%0d exp=606", dut.x_r[0]); end
        total++; if (dut.speed_r !== 4'd5) begin bad++; $display("FAIL cr_speed5 got=%0d exp=5", dut.speed_r); end
        frame(1'b0, 1'b1, h);
        total++; if (dut.x_r[0] !== 10'd608) begin bad++; $display("FAIL cr_x608 got=%0d exp=608", dut.x_r[0]); end
        total++; if (dut.dx_r[0] !== 1'b1) begin bad++; $display("FAIL cr_dx1 got=%b exp=1", dut.dx_r[0]); end
        frame(1'b0, 1'b0, h);
        total++; if (dut.x_r[0] !== 10'd604) begin bad++; $display("FAIL cr_x604 got=%0d exp=604", dut.x_r[0]); end
    endtask

    task automatic test_clamp_left;
        int h;
        do_reset();
        frames(3, 1'b1, 1'b0);
        frames(20, 1'b0, 1'b0);
        frame(1'b0, 1'b0, h);
        total++; if (dut.x_r[1] !== 10'd3) begin bad++; $display("FAIL cl_x3 got=%0d exp=3", dut.x_r[1]); end
`ifdef PXS_BALL_HIT_EN
        total++; if (h !== 0) begin bad++; $display("FAIL cl_nohit got=%0d exp=0", h); end
`endif
        frame(1'b0, 1'b0, h);
        total++; if (dut.x_r[1] !== 10'd0) begin bad++; $display("FAIL cl_x0 got=%0d exp=0", dut.x_r[1]); end
        total++; if (dut.dx_r[1] !== 1'b0) begin bad++; $display("FAIL cl_dx0 got=%b exp=0", dut.dx_r[1]); end
`ifdef PXS_BALL_HIT_EN
        total++; if (h !== 1) begin bad++; $display("FAIL cl_hit_pulse got=%0d exp=1", h); end
`endif
    endtask

    task automatic test_speed;
        int h;
        do_reset();
        frame(1'b0, 1'b1, h);
        total++; if (dut.speed_r !== 4'd0) begin bad++; $display("FAIL sp_zero got=%0d exp=0", dut.speed_r); end
        total++; if (dut.x_r[1] !== 10'd96) begin bad++; $display("FAIL sp_still_x1 got=%0d exp=96", dut.x_r[1]); end
        total++; if (dut.y_r[1] !== 10'd16) begin bad++; $display("FAIL sp_still_y1 got=%0d exp=16", dut.y_r[1]); end
        total++; if (dut.x_r[0] !== 10'd0) begin bad++; $display("FAIL sp_still_x0 got=%0d exp=0", dut.x_r[0]); end
        frame(1'b0, 1'b1, h);
        total++; if (dut.speed_r !== 4'd0) begin bad++; $display("FAIL sp_floor got=%0d exp=0", dut.speed_r); end
        frames(16, 1'b1, 1'b0);
        total++; if (dut.speed_r !== 4'd15) begin bad++; $display("FAIL sp_ceiling got=%0d exp=15", dut.speed_r); end
        frame(1'b1, 1'b1, h);
        total++; if (dut.speed_r !== 4'd15) begin bad++; $display("FAIL sp_both15 got=%0d exp=15", dut.speed_r); end
        frame(1'b0, 1'b1, h);
        frame(1'b1, 1'b1, h);
        total++; if (dut.speed_r !== 4'd14) begin bad++; $display("FAIL sp_both14 got=%0d exp=14", dut.speed_r); end
        frames(16, 1'b0, 1'b1);
        total++; if (dut.speed_r !== 4'd0) begin bad++; $display("FAIL sp_down0 got=%0d exp=0", dut.speed_r); end
    endtask

    task automatic test_overlap;
        logic [STR_W-1:0] o;
        do_reset();
        frames(48, 1'b0, 1'b0);
        probe(BG, 10'd50, 10'd70, 1'b1, o);
        total++; if (o !== pix(C0, 10'd50, 10'd70, 1'b1)) begin bad++; $display("FAIL ov_prio got=%h exp=%h", o, pix(C0, 10'd50, 10'd70, 1'b1)); end
        probe(BG, 10'd79, 10'd95, 1'b1, o);
        total++; if (o !== pix(C1, 10'd79, 10'd95, 1'b1)) begin bad++; $display("FAIL ov_b1only got=%h exp=%h", o, pix(C1, 10'd79, 10'd95, 1'b1)); end
        probe(BG, 10'd80, 10'd70, 1'b1, o);
        total++; if (o !== pix(BG, 10'd80, 10'd70, 1'b1)) begin bad++; $display("FAIL ov_outside got=%h exp=%h", o, pix(BG, 10'd80, 10'd70, 1'b1)); end
        probe(BG, 10'd50, 10'd70, 1'b0, o);
        total++; if (o !== pix(BG, 10'd50, 10'd70, 1'b0)) begin bad++; $display("FAIL ov_inactive got=%h exp=%h", o, pix(BG, 10'd50, 10'd70, 1'b0)); end
        en_i = 1'b0;
        probe(BG, 10'd50, 10'd70, 1'b1, o);
        en_i = 1'b1;
        total++; if (o !== pix(BG, 10'd50, 10'd70, 1'b1)) begin bad++; $display("FAIL ov_disabled got=%h exp=%h", o, pix(BG, 10'd50, 10'd70, 1'b1)); end
    endtask

    task automatic test_reset_mid;
        int h;
        do_reset();
        frame(1'b0, 1'b0, h);
        RGBStr_i = pix(3'b000, 10'd639, 10'd479, 1'b0);
        tick();
        idle_px();
        tick();
        total++; if (dut.state_r !== UPD) begin bad++; $display("FAIL rm_in_upd got=%0d exp=1", dut.state_r); end
        total++; if (dut.idx_r !== 3'd1) begin bad++; $display("FAIL rm_idx1 got=%0d exp=1", dut.idx_r); end
        total++; if (dut.x_r[0] !== 10'd2) begin bad++; $display("FAIL rm_x0_partial got=%0d exp=2", dut.x_r[0]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (dut.state_r !== IDLE) begin bad++; $display("FAIL rm_idle got=%0d exp=0", dut.state_r); end
        total++; if (dut.x_r[0] !== 10'd0) begin bad++; $display("FAIL rm_x0 got=%0d exp=0", dut.x_r[0]); end
        total++; if (dut.y_r[0] !== 10'd0) begin bad++; $display("FAIL rm_y0 got=%0d exp=0", dut.y_r[0]); end
        total++; if (dut.x_r[1] !== 10'd96) begin bad++; $display("FAIL rm_x1 got=%0d exp=96", dut.x_r[1]); end
        frame(1'b0, 1'b0, h);
        total++; if (dut.x_r[0] !== 10'd1) begin bad++; $display("FAIL rm_next_x0 got=%0d exp=1", dut.x_r[0]); end
        total++; if (dut.x_r[1] !== 10'd95) begin bad++; $display("FAIL rm_next_x1 got=%0d exp=95", dut.x_r[1]); end
    endtask

    task automatic test_back_to_back;
        do_reset();
        RGBStr_i = pix(3'b000, 10'd639, 10'd479, 1'b0);
        tick();
        tick();
        idle_px();
        for (int k = 0; k < 6; k++) tick();
        total++; if (dut.x_r[0] !== 10'd1) begin bad++; $display("FAIL b2b_single got=%0d exp=1", dut.x_r[0]); end
        en_i = 1'b0;
        RGBStr_i = pix(3'b000, 10'd639, 10'd479, 1'b0);
        tick();
        idle_px();
        for (int k = 0; k < 6; k++) tick();
        en_i = 1'b1;
        total++; if (dut.x_r[0] !== 10'd1) begin bad++; $display("FAIL b2b_frozen got=%0d exp=1", dut.x_r[0]); end
    endtask

    initial begin
        idle_px();
        test_reset();
        test_overlay();
        test_clamp_right();
        test_clamp_left();
        test_speed();
        test_overlap();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
